// File: rtl/id_stage_pipe_pkg.sv
// id_pkg: shared constants for the instruction-decode stage.
//   - opcode constants (op field, instr[31:28])
//   - bit positions inside the 8-bit ctrl bundle
//   - bit positions of the instruction fields
package id_pkg;

  // Opcodes. 0xxx is the ALU group, and 01xx is its immediate form.
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_BR  = 4'b1010;
  localparam logic [3:0] OP_RSV = 4'b1011;
  localparam logic [3:0] OP_JR  = 4'b1110;

  // ctrl = {jump, branch, mem_to_reg, mem_write, reg_write, alu_src, mbs, negar}
  localparam int C_JUMP       = 7;
  localparam int C_BRANCH     = 6;
  localparam int C_MEM_TO_REG = 5;
  localparam int C_MEM_WRITE  = 4;
  localparam int C_REG_WRITE  = 3;
  localparam int C_ALU_SRC    = 2;
  localparam int C_MBS        = 1;
  localparam int C_NEGAR      = 0;

  // Instruction field positions.
  localparam int F_OP_HI = 31;
  localparam int F_OP_LO = 28;
  localparam int F_RD_HI = 27;
  localparam int F_RD_LO = 24;
  localparam int F_RS_HI = 23;
  localparam int F_RS_LO = 20;
  localparam int F_FN_HI = 19;
  localparam int F_FN_LO = 17;
  localparam int F_RT_HI = 16;
  localparam int F_RT_LO = 13;

  // Top bit of each immediate form: short (17 bits), jr (24 bits), jump (28 bits).
  localparam int IMM_S_HI  = 16;
  localparam int IMM_JR_HI = 23;
  localparam int IMM_J_HI  = 27;

endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: register file with two combinational read ports and one
// synchronous write port.
//   clk, rst (async, active-low; clears every register)
//   we, waddr, wdata     : write port
//   raddr_a/b, rdata_a/b : read ports
// Addresses >= NREGS read 0 and ignore writes. With R0_ZERO != 0, register 0
// is hard-wired to 0.
// Optional macro ID_BYPASS_EN: a read of the address being written in the same
// cycle returns wdata. Without it, reads return the value held before the write.
module regfile_2r1w #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 16,
  parameter int R0_ZERO = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [3:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [3:0]      raddr_a,
  input  logic [3:0]      raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b
);

  localparam logic [4:0] NREGS_L = 5'(NREGS);

  // The 4-bit address space always has 16 slots. Slots that are not real
  // registers are tied to zero, so reads need no range check.
  logic [XLEN-1:0] rf [16];
  logic            wr_ok;

  assign wr_ok = ({1'b0, waddr} < NREGS_L) && !((R0_ZERO != 0) && (waddr == 4'd0));

  for (genvar i = 0; i < 16; i++) begin : g_slot
    if ((i < NREGS) && !((R0_ZERO != 0) && (i == 0))) begin : g_reg
      logic [XLEN-1:0] reg_d;
      logic [XLEN-1:0] reg_q;

      always_comb begin
        reg_d = reg_q;
        if (we && wr_ok && (waddr == 4'(i))) reg_d = wdata;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) reg_q <= '0;
        else      reg_q <= reg_d;
      end

      assign rf[i] = reg_q;
    end else begin : g_zero
      assign rf[i] = '0;
    end
  end

  always_comb begin
    rdata_a = rf[raddr_a];
    rdata_b = rf[raddr_b];
`ifdef ID_BYPASS_EN
    if (we && wr_ok && (waddr == raddr_a)) rdata_a = wdata;
    if (we && wr_ok && (waddr == raddr_b)) rdata_b = wdata;
`endif
  end

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: pipelined instruction-decode stage with a one-cycle latency.
//   in_valid/in_ready, instr, pc_in : instruction from IF/ID
//   flush                           : kills the input and the ID/EX contents
//   wb_we, wb_addr, wb_data         : register-file writeback
//   out_valid/out_ready             : ID/EX register handshake toward EX
//   dato1, dato2, inm_ext, pc_out, rd_out, funct, ctrl : ID/EX fields
// Handshake: a transfer happens on a rising edge where valid && ready. The
// source holds its payload until that edge, and the ID/EX outputs stay stable
// while out_valid && !out_ready.
// Optional macro ID_BYPASS_EN (in regfile_2r1w): writeback-to-read bypass
// within the same cycle.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREGS   = 16,
  parameter int R0_ZERO = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [3:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] dato1,
  output logic [XLEN-1:0] dato2,
  output logic [XLEN-1:0] inm_ext,
  output logic [XLEN-1:0] pc_out,
  output logic [3:0]      rd_out,
  output logic [2:0]      funct,
  output logic [7:0]      ctrl
);

  logic [3:0] op, f_rd, f_rs, f_rt;
  logic [2:0] f_fn;

  assign op   = instr[F_OP_HI:F_OP_LO];
  assign f_rd = instr[F_RD_HI:F_RD_LO];
  assign f_rs = instr[F_RS_HI:F_RS_LO];
  assign f_fn = instr[F_FN_HI:F_FN_LO];
  assign f_rt = instr[F_RT_HI:F_RT_LO];

  logic [3:0]      ra, rb;
  logic            use_a, use_b;
  logic [7:0]      ctrl_dec;
  logic [XLEN-1:0] imm_dec;
  logic [XLEN-1:0] rdata_a, rdata_b;

  regfile_2r1w #(.XLEN(XLEN), .NREGS(NREGS), .R0_ZERO(R0_ZERO)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (ra),
    .raddr_b (rb),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  // Decoder and immediate extender. use_a/use_b mark which read ports carry a
  // real source operand; only those take part in the load-use check.
  always_comb begin
    ctrl_dec = '0;
    ra       = f_rs;
    rb       = f_rt;
    use_a    = 1'b0;
    use_b    = 1'b0;
    imm_dec  = XLEN'($signed(instr[IMM_S_HI:0]));
    if (!op[3]) begin
      ctrl_dec[C_REG_WRITE] = 1'b1;
      ctrl_dec[C_NEGAR]     = op[0];
      ctrl_dec[C_MBS]       = op[1];
      use_a                 = 1'b1;
      // 01xx swaps the rt operand for the immediate.
      if (op[2]) ctrl_dec[C_ALU_SRC] = 1'b1;
      else       use_b               = 1'b1;
    end else begin
      case (op)
        OP_LW: begin
          ctrl_dec[C_REG_WRITE]  = 1'b1;
          ctrl_dec[C_MEM_TO_REG] = 1'b1;
          ctrl_dec[C_ALU_SRC]    = 1'b1;
          use_a                  = 1'b1;
        end
        OP_SW: begin
          ctrl_dec[C_MEM_WRITE] = 1'b1;
          ctrl_dec[C_ALU_SRC]   = 1'b1;
          rb                    = f_rd;
          use_a                 = 1'b1;
          use_b                 = 1'b1;
        end
        OP_BR: begin
          ctrl_dec[C_BRANCH] = 1'b1;
          ra                 = f_rd;
          rb                 = f_rs;
          use_a              = 1'b1;
          use_b              = 1'b1;
        end
        OP_RSV: begin
          // Reserved: flows through as a NOP.
        end
        default: begin
          ctrl_dec[C_JUMP]   = 1'b1;
          ctrl_dec[C_BRANCH] = 1'b1;
          if (op == OP_JR) begin
            ra      = f_rd;
            use_a   = 1'b1;
            imm_dec = XLEN'($signed(instr[IMM_JR_HI:0]));
          end else begin
            imm_dec = XLEN'($signed(instr[IMM_J_HI:0]));
          end
        end
      endcase
    end
  end

  // ID/EX register.
  logic            valid_d, valid_q;
  logic [XLEN-1:0] dato1_d, dato1_q, dato2_d, dato2_q;
  logic [XLEN-1:0] imm_d, imm_q, pc_d, pc_q;
  logic [3:0]      rd_d, rd_q;
  logic [2:0]      fn_d, fn_q;
  logic [7:0]      ctrl_d, ctrl_q;
  logic            stall, load;

  // Load-use interlock: the load in ID/EX has not produced its data yet.
  assign stall = valid_q && ctrl_q[C_MEM_TO_REG]
               && ((use_a && (ra == rd_q)) || (use_b && (rb == rd_q)))
               && !((R0_ZERO != 0) && (rd_q == 4'd0));

  // A flush takes and drops the input, so in_ready stays high during it.
  assign in_ready = flush || (!stall && (!valid_q || out_ready));
  assign load     = in_valid && in_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    dato1_d = dato1_q;
    dato2_d = dato2_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    rd_d    = rd_q;
    fn_d    = fn_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      dato1_d = rdata_a;
      dato2_d = rdata_b;
      imm_d   = imm_dec;
      pc_d    = pc_in;
      rd_d    = f_rd;
      fn_d    = f_fn;
      ctrl_d  = ctrl_dec;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      dato1_q <= '0;
      dato2_q <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
      fn_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      dato1_q <= dato1_d;
      dato2_q <= dato2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      fn_q    <= fn_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign out_valid = valid_q;
  assign dato1     = dato1_q;
  assign dato2     = dato2_q;
  assign inm_ext   = imm_q;
  assign pc_out    = pc_q;
  assign rd_out    = rd_q;
  assign funct     = fn_q;
  assign ctrl      = ctrl_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed bench for id_stage_pipe (XLEN=32, NREGS=16,
// R0_ZERO=1). The driver pushes expected ID/EX contents into exp_q as each
// instruction is accepted. The monitor pops and compares on every EX handshake.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc_in = '0;
  logic        flush = 1'b0;
  logic        wb_we = 1'b0;
  logic [3:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] dato1, dato2, inm_ext, pc_out;
  logic [3:0]  rd_out;
  logic [2:0]  funct;
  logic [7:0]  ctrl;

  id_stage_pipe #(.XLEN(32), .NREGS(16), .R0_ZERO(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_in(pc_in), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .dato1(dato1), .dato2(dato2), .inm_ext(inm_ext), .pc_out(pc_out),
    .rd_out(rd_out), .funct(funct), .ctrl(ctrl)
  );

  // Clock / reset block. rst is driven from the main sequence.
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  mask;   // {check a, check b, check imm}
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  rd;
    logic [2:0]  fn;
    logic [7:0]  ctrl;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);
  localparam logic [2:0] M_A = 3'b100, M_B = 3'b010, M_I = 3'b001;

`ifdef ID_BYPASS_EN
  localparam logic [31:0] BYP_R5 = 32'hAA;
`else
  localparam logic [31:0] BYP_R5 = 32'h55;
`endif

  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int dummy;
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] mk_ins(input logic [3:0] op, input logic [3:0] rd,
      input logic [3:0] rs, input logic [2:0] fn, input logic [3:0] rt, input logic [12:0] low);
    return {op, rd, rs, fn, rt, low};
  endfunction

  function automatic exp_t mk_exp(input logic [2:0] mask, input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rd, input logic [2:0] fn,
      input logic [7:0] c);
    exp_t e;
    e.mask = mask; e.a = a; e.b = b; e.imm = imm; e.pc = pc; e.rd = rd; e.fn = fn; e.ctrl = c;
    return e;
  endfunction

  // Driver tasks.
  task automatic wb_write(input logic [3:0] addr, input logic [31:0] data);
    wb_we = 1'b1; wb_addr = addr; wb_data = data;
    @(posedge clk); #1;
    wb_we = 1'b0;
  endtask

  // Presents an instruction until it is accepted (bounded). Reports the
  // number of cycles spent waiting with in_ready low.
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input exp_t e, output int waits);
    logic ok;
    ok = 1'b0; waits = 0;
    in_valid = 1'b1; instr = ins; pc_in = pc;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      if (!ok) waits++;
    end
    if (ok) exp_q.push_back(EXP_W'(e));
    else begin
      checks++; failures++;
      $display("FAIL issue_timeout actual=in_ready_low required=accept pc=%0h", pc);
    end
    #1 in_valid = 1'b0;
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output actual=pc_%0h required=no_output", pc_out);
      end else begin
        mon_e = exp_t'(exp_q.pop_front());
        if (mon_e.mask[2]) chk("dato1", dato1, mon_e.a);
        if (mon_e.mask[1]) chk("dato2", dato2, mon_e.b);
        if (mon_e.mask[0]) chk("inm_ext", inm_ext, mon_e.imm);
        chk("pc_out", pc_out, mon_e.pc);
        chk("rd_out", {28'd0, rd_out}, {28'd0, mon_e.rd});
        chk("funct", {29'd0, funct}, {29'd0, mon_e.fn});
        chk("ctrl", {24'd0, ctrl}, {24'd0, mon_e.ctrl});
      end
    end
  end

  int w;

  initial begin
    // Reset values, asynchronously, before any clock edge.
    #2;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_dato1", dato1, 32'd0);
    chk("reset_ctrl", {24'd0, ctrl}, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;

    // Register write, then an ALU read of the same register on both ports.
    wb_write(4'd3, 32'h1234);
    wb_write(4'd7, 32'h77);
    wb_write(4'd5, 32'h55);
    issue(mk_ins(4'h0, 4'd1, 4'd3, 3'd5, 4'd3, 13'd0), 32'h100,
          mk_exp(M_A | M_B, 32'h1234, 32'h1234, 32'h0, 32'h100, 4'd1, 3'd5, 8'h08), dummy);
    // r0 ignores writes.
    wb_write(4'd0, 32'hDEAD);
    issue(mk_ins(4'h0, 4'd2, 4'd0, 3'd0, 4'd3, 13'd0), 32'h104,
          mk_exp(M_A | M_B, 32'h0, 32'h1234, 32'h0, 32'h104, 4'd2, 3'd0, 8'h08), dummy);

    // Writeback to r5 in the same cycle as decoding rs = rt = 5.
    wb_we = 1'b1; wb_addr = 4'd5; wb_data = 32'hAA;
    issue(mk_ins(4'h0, 4'd4, 4'd5, 3'd1, 4'd5, 13'd0), 32'h108,
          mk_exp(M_A | M_B, BYP_R5, BYP_R5, 32'h0, 32'h108, 4'd4, 3'd1, 8'h08), dummy);
    wb_we = 1'b0;
    issue(mk_ins(4'h0, 4'd4, 4'd5, 3'd1, 4'd3, 13'd0), 32'h10C,
          mk_exp(M_A | M_B, 32'hAA, 32'h1234, 32'h0, 32'h10C, 4'd4, 3'd1, 8'h08), dummy);

    // Store, branch, ALU-immediate forms, reserved opcode.
    issue(mk_ins(4'h9, 4'd3, 4'd5, 3'd0, 4'd0, 13'h0008), 32'h110,
          mk_exp(M_A | M_B | M_I, 32'hAA, 32'h1234, 32'h8, 32'h110, 4'd3, 3'd0, 8'h14), dummy);
    issue(mk_ins(4'hA, 4'd7, 4'd3, 3'd6, 4'hF, 13'h1FF0), 32'h114,
          mk_exp(M_A | M_B | M_I, 32'h77, 32'h1234, 32'hFFFF_FFF0, 32'h114, 4'd7, 3'd6, 8'h40), dummy);
    issue(mk_ins(4'h5, 4'd6, 4'd3, 3'd2, 4'd0, 13'd5), 32'h118,
          mk_exp(M_A | M_I, 32'h1234, 32'h0, 32'h5, 32'h118, 4'd6, 3'd2, 8'h0D), dummy);
    issue(mk_ins(4'h6, 4'd6, 4'd7, 3'd0, 4'd8, 13'd0), 32'h11C,
          mk_exp(M_A | M_I, 32'h77, 32'h0, 32'hFFFF_0000, 32'h11C, 4'd6, 3'd0, 8'h0E), dummy);
    issue(mk_ins(4'hB, 4'd1, 4'd3, 3'd0, 4'd0, 13'd0), 32'h120,
          mk_exp(3'b000, 32'h0, 32'h0, 32'h0, 32'h120, 4'd1, 3'd0, 8'h00), dummy);

    // Jumps: register + 24-bit immediate, then PC-relative 28-bit immediate.
    issue({4'hE, 4'd3, 24'hFFFFF0}, 32'h124,
          mk_exp(M_A | M_I, 32'h1234, 32'h0, 32'hFFFF_FFF0, 32'h124, 4'd3, 3'd7, 8'hC0), dummy);
    issue({4'hC, 28'h0000010}, 32'h128,
          mk_exp(M_I, 32'h0, 32'h0, 32'h10, 32'h128, 4'd0, 3'd0, 8'hC0), dummy);

    // Load-use: LW r7 then ALU rs = 7.
    issue(mk_ins(4'h8, 4'd7, 4'd3, 3'd0, 4'hF, 13'h1FFC), 32'h12C,
          mk_exp(M_A | M_I, 32'h1234, 32'h0, 32'hFFFF_FFFC, 32'h12C, 4'd7, 3'd0, 8'h2C), dummy);
    in_valid = 1'b1; instr = mk_ins(4'h0, 4'd2, 4'd7, 3'd3, 4'd3, 13'd0); pc_in = 32'h130;
    @(negedge clk);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("bubble_out_valid", {31'd0, out_valid}, 32'd0);
    chk("after_stall_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(EXP_W'(mk_exp(M_A | M_B, 32'h77, 32'h1234, 32'h0, 32'h130, 4'd2, 3'd3, 8'h08)));
    @(posedge clk); #1 in_valid = 1'b0;

    // LW r0 followed by a use of r0: no interlock.
    issue(mk_ins(4'h8, 4'd0, 4'd3, 3'd0, 4'd0, 13'd0), 32'h134,
          mk_exp(M_A | M_I, 32'h1234, 32'h0, 32'h0, 32'h134, 4'd0, 3'd0, 8'h2C), dummy);
    issue(mk_ins(4'h0, 4'd1, 4'd0, 3'd0, 4'd0, 13'd0), 32'h138,
          mk_exp(M_A | M_B, 32'h0, 32'h0, 32'h0, 32'h138, 4'd1, 3'd0, 8'h08), w);
    chk("no_stall_r0_waits", 32'(w), 32'd0);

    // Back-pressure for three cycles, then flush.
    @(posedge clk); #1 out_ready = 1'b0;
    issue(mk_ins(4'h0, 4'd5, 4'd3, 3'd4, 4'd7, 13'd0), 32'h200,
          mk_exp(M_A | M_B, 32'h1234, 32'h77, 32'h0, 32'h200, 4'd5, 3'd4, 8'h08), dummy);
    in_valid = 1'b1; instr = mk_ins(4'h0, 4'd6, 4'd5, 3'd0, 4'd5, 13'd0); pc_in = 32'h204;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_dato1", dato1, 32'h1234);
      chk("bp_dato2", dato2, 32'h77);
      chk("bp_pc", pc_out, 32'h200);
    end
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();  // the held instruction was killed
    @(negedge clk);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("flush_input_discarded", {31'd0, out_valid}, 32'd0);

    // Reset while out_valid is high, with no clock edge involved.
    @(posedge clk); #1 out_ready = 1'b0;
    issue(mk_ins(4'h0, 4'd1, 4'd3, 3'd0, 4'd7, 13'd0), 32'h300,
          mk_exp(M_A | M_B, 32'h1234, 32'h77, 32'h0, 32'h300, 4'd1, 3'd0, 8'h08), dummy);
    chk("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_dato1", dato1, 32'd0);
    chk("rst_ctrl", {24'd0, ctrl}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b1; out_ready = 1'b1;
    issue(mk_ins(4'h0, 4'd2, 4'd3, 3'd0, 4'd7, 13'd0), 32'h304,
          mk_exp(M_A | M_B, 32'h0, 32'h0, 32'h0, 32'h304, 4'd2, 3'd0, 8'h08), dummy);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain actual=%0d_pending required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
